ball_ctl: RTL and testbench
===========================

Name: ball_ctl

Overview:
- Computes the ball's top-left position (xpos, ypos) once per video frame and feeds it directly to the ball drawing stage.
- Handles serve, wall bounces, paddle hits and misses.
- Emits one-cycle event pulses for the scoring and sound logic.
- Positions change only at the start of vsync, so the drawn ball never tears mid-frame.

Parameters:
- H_RES, 800, active pixels per line
- V_RES, 600, active lines per frame
- BALL_SIZE, 16, ball edge length in pixels
- SPEED_X, 4, horizontal step per frame
- SPEED_Y, 2, vertical step per frame
- PADDLE_W, 16, paddle width
- PADDLE_H, 96, paddle height
- L_PAD_X, 32, left paddle left edge
- R_PAD_X, 752, right paddle left edge
- SERVE_FRAMES, 60, frames the ball rests at centre before moving

Ports:
- pclk  in  1  pixel clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- vsync_in  in  1  vertical sync from the timing chain; its rising edge is the frame tick
- start  in  1  level; begins play from IDLE
- pause  in  1  level; while 1, frame ticks are ignored
- lpad_y  in  12  left paddle top edge
- rpad_y  in  12  right paddle top edge
- xpos  out  12  ball left edge
- ypos  out  12  ball top edge
- hit  out  1  one-cycle pulse on a paddle hit
- goal_l  out  1  one-cycle pulse; left player scores
- goal_r  out  1  one-cycle pulse; right player scores
- playing  out  1  1 in SERVE or PLAY

Behaviour:
- Reset values:
  - xpos = CX = (H_RES-BALL_SIZE)/2 = 392; ypos = CY = 292.
  - hit = goal_l = goal_r = playing = 0.
  - State IDLE, dir_x = right, dir_y = down, serve counter 0, vsync_prev 0.
- Frame tick: tick = vsync_in & ~vsync_prev & ~pause, with vsync_prev registered every cycle.
  - All position updates happen on the clock edge where tick = 1.
  - xpos/ypos hold on every other cycle.
- IDLE:
  - Ball at (CX, CY).
  - start = 1 on any cycle -> SERVE, counter cleared.
- SERVE:
  - Ball at (CX, CY); counter increments on each tick.
  - When counter = SERVE_FRAMES-1 and tick -> PLAY.
  - The ball's first move happens on the following tick.
- PLAY, on each tick, arithmetic is in 13-bit signed to catch underflow.
  - Vertical, moving up: yn = ypos-SPEED_Y. If yn <= 0: ypos = 0, dir_y = down. Else ypos = yn.
  - Vertical, moving down: yn = ypos+SPEED_Y. If yn >= V_RES-BALL_SIZE: ypos = V_RES-BALL_SIZE, dir_y = up. Else ypos = yn.
  - Overlap with a paddle (computed against the current ypos, before the vertical update): ypos+BALL_SIZE > pad_y and ypos < pad_y+PADDLE_H.
  - Moving left: xn = xpos-SPEED_X; face FL = L_PAD_X+PADDLE_W = 48.
    - If xn <= FL and xpos >= FL and left overlap: xpos = FL, dir_x = right, hit pulse.
    - Else if xn <= 0: goal_r pulse, state -> GOAL.
    - Else xpos = xn.
  - Moving right: xn = xpos+SPEED_X; face FR = R_PAD_X-BALL_SIZE = 736.
    - If xn >= FR and xpos <= FR and right overlap: xpos = FR, dir_x = left, hit pulse.
    - Else if xn >= H_RES-BALL_SIZE: goal_l pulse, state -> GOAL.
    - Else xpos = xn.
  - Wall and paddle events on the same tick are both applied (corner hit).
  - A ball past a paddle face without a hit continues until it reaches the screen edge.
- GOAL (one cycle):
  - Ball set to (CX, CY).
  - dir_x set toward the player who conceded: after goal_r serve left, after goal_l serve right. dir_y unchanged.
  - Next state SERVE, counter cleared.
- Pulses: hit, goal_l and goal_r are registered and last exactly one pclk cycle. goal_l and goal_r are never both 1.
- start is ignored outside IDLE.
- pause freezes position and serve counter; a vsync edge seen during pause is lost, not deferred.
- Reset asserted mid-operation: all state and outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared pong package holds:
  - State enum: IDLE, SERVE, PLAY, GOAL.
  - Screen constants H_RES and V_RES.
  - BALL_SIZE and the paddle geometry constants, which are also used by the paddle and draw stages.
- One natural sub-module: edge_detect, the rising-edge detector for vsync_in.
- Collision logic stays inline.

Test Plan:
- Reset, then hold rst = 1 with no start for 10 frames -> xpos = 392, ypos = 292, playing = 0, no pulses.
- start pulse, then 60 vsync edges -> ball still at centre, playing = 1. Tick 61 -> xpos = 396, ypos = 294.
- Force ypos = 2 moving up, tick -> ypos = 0, dir down. Next tick -> ypos = 2. Separately, ypos = 583 moving down, tick -> ypos = 584, then 582.
- xpos = 50 moving left, lpad_y = 250, ypos = 292, tick -> xpos = 48, hit high exactly 1 cycle. Next tick -> xpos = 52.
- Same as the previous case with lpad_y = 500 -> ball passes the face. When xn <= 0, goal_r pulses once, ball recentres, and the serve after 60 frames moves left.
- Reset asserted mid-PLAY with ball at (600, 100) -> outputs immediately (392, 292), state IDLE. start high during SERVE/PLAY has no effect. pause = 1 for 5 frames -> position unchanged.

Source files
------------

// File: rtl/ball_ctl_pkg.sv
// Shared pong definitions: game states, screen size and ball/paddle geometry
// used by the ball controller and the paddle and draw stages.
package ball_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        PLAY,
        GOAL
    } state_e;

    localparam int H_RES     = 800;
    localparam int V_RES     = 600;
    localparam int BALL_SIZE = 16;
    localparam int PADDLE_W  = 16;
    localparam int PADDLE_H  = 96;
    localparam int L_PAD_X   = 32;
    localparam int R_PAD_X   = 752;

    // Top-left coordinate that centres the ball along an axis of length res.
    function automatic logic [11:0] centre(input int res);
        return 12'((res - BALL_SIZE) / 2);
    endfunction

endpackage

// File: rtl/ball_ctl_if.sv
// Ball controller bus: frame timing, control levels and paddle positions in;
// ball position, event pulses and play status out.
interface ball_ctl_if;

    logic        vsync_in;
    logic        start;
    logic        pause;
    logic [11:0] lpad_y;
    logic [11:0] rpad_y;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        hit;
    logic        goal_l;
    logic        goal_r;
    logic        playing;

    modport master (
        output vsync_in, start, pause, lpad_y, rpad_y,
        input  xpos, ypos, hit, goal_l, goal_r, playing
    );

    modport slave (
        input  vsync_in, start, pause, lpad_y, rpad_y,
        output xpos, ypos, hit, goal_l, goal_r, playing
    );

endinterface

// File: rtl/ball_ctl_edge_detect.sv
// Rising-edge detector: rise_o is high for the cycle where d_i is 1 and was 0
// on the previous clock.
module edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_q <= 1'b0;
        else         prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/ball_ctl.sv
// Pong ball controller: moves the ball once per frame tick, bounces it off walls
// and paddles, and reports hits and goals as one-cycle pulses.
module ball_ctl
    import ball_ctl_pkg::*;
#(
    parameter int SPEED_X      = 4,
    parameter int SPEED_Y      = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic      pclk,
    input  logic      rst,
    ball_ctl_if.slave bus
);

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic [11:0]        CX   = centre(H_RES);
    localparam logic [11:0]        CY   = centre(V_RES);
    localparam logic signed [12:0] FL   = 13'(L_PAD_X + PADDLE_W);
    localparam logic signed [12:0] FR   = 13'(R_PAD_X - BALL_SIZE);
    localparam logic signed [12:0] XMAX = 13'(H_RES - BALL_SIZE);
    localparam logic signed [12:0] YMAX = 13'(V_RES - BALL_SIZE);
    localparam logic signed [12:0] SX   = 13'(SPEED_X);
    localparam logic signed [12:0] SY   = 13'(SPEED_Y);
    localparam logic [12:0]        BS_U = 13'(BALL_SIZE);
    localparam logic [12:0]        PH_U = 13'(PADDLE_H);
    localparam logic [CW-1:0]      LAST = CW'(SERVE_FRAMES - 1);

    state_e        state_q, state_d;
    logic [11:0]   x_q, x_d, y_q, y_d;
    logic          right_q, right_d;
    logic          down_q, down_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d, goal_l_q, goal_l_d, goal_r_q, goal_r_d;

    logic               vs_rise, tick;
    logic signed [12:0] xs, ys, xn, yn;
    logic [12:0]        yu, lpu, rpu;
    logic               l_ovl, r_ovl;

    edge_detect u_vs_edge (
        .clk_i  (pclk),
        .rst_ni (rst),
        .d_i    (bus.vsync_in),
        .rise_o (vs_rise)
    );

    assign tick = vs_rise & ~bus.pause;

    assign xs = $signed({1'b0, x_q});
    assign ys = $signed({1'b0, y_q});
    assign xn = right_q ? xs + SX : xs - SX;
    assign yn = down_q  ? ys + SY : ys - SY;

    // Overlap is judged unsigned and one bit wider so pad_y+PADDLE_H cannot wrap.
    assign yu    = {1'b0, y_q};
    assign lpu   = {1'b0, bus.lpad_y};
    assign rpu   = {1'b0, bus.rpad_y};
    assign l_ovl = (yu + BS_U > lpu) && (yu < lpu + PH_U);
    assign r_ovl = (yu + BS_U > rpu) && (yu < rpu + PH_U);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        right_d  = right_q;
        down_d   = down_q;
        cnt_d    = cnt_q;
        hit_d    = 1'b0;
        goal_l_d = 1'b0;
        goal_r_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                x_d = CX;
                y_d = CY;
                if (bus.start) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
            end
            SERVE: begin
                x_d = CX;
                y_d = CY;
                if (tick) begin
                    if (cnt_q == LAST) state_d = PLAY;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PLAY: begin
                if (tick) begin
                    if (down_q) begin
                        if (yn >= YMAX) begin
                            y_d    = YMAX[11:0];
                            down_d = 1'b0;
                        end else begin
                            y_d = yn[11:0];
                        end
                    end else begin
                        if (yn <= 13'sd0) begin
                            y_d    = '0;
                            down_d = 1'b1;
                        end else begin
                            y_d = yn[11:0];
                        end
                    end

                    if (!right_q) begin
                        if (xn <= FL && xs >= FL && l_ovl) begin
                            x_d     = FL[11:0];
                            right_d = 1'b1;
                            hit_d   = 1'b1;
                        end else if (xn <= 13'sd0) begin
                            goal_r_d = 1'b1;
                            state_d  = GOAL;
                        end else begin
                            x_d = xn[11:0];
                        end
                    end else begin
                        if (xn >= FR && xs <= FR && r_ovl) begin
                            x_d     = FR[11:0];
                            right_d = 1'b0;
                            hit_d   = 1'b1;
                        end else if (xn >= XMAX) begin
                            goal_l_d = 1'b1;
                            state_d  = GOAL;
                        end else begin
                            x_d = xn[11:0];
                        end
                    end
                end
            end
            GOAL: begin
                // The goal pulse is still high here and tells us who conceded.
                x_d     = CX;
                y_d     = CY;
                right_d = ~goal_r_q;
                state_d = SERVE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            x_q      <= CX;
            y_q      <= CY;
            right_q  <= 1'b1;
            down_q   <= 1'b1;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            goal_l_q <= 1'b0;
            goal_r_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            right_q  <= right_d;
            down_q   <= down_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            goal_l_q <= goal_l_d;
            goal_r_q <= goal_r_d;
        end
    end

    assign bus.xpos    = x_q;
    assign bus.ypos    = y_q;
    assign bus.hit     = hit_q;
    assign bus.goal_l  = goal_l_q;
    assign bus.goal_r  = goal_r_q;
    assign bus.playing = (state_q == SERVE) || (state_q == PLAY);

endmodule

// File: tb/tb_ball_ctl.sv
// Directed bench for ball_ctl: serve, wall and paddle bounces, misses on both
// sides, pause, asynchronous reset and start-ignored-while-playing.
module tb_ball_ctl;

    logic pclk = 1'b0;
    logic rst  = 1'b0;

    ball_ctl_if bus ();

    ball_ctl #(
        .SPEED_X      (4),
        .SPEED_Y      (2),
        .SERVE_FRAMES (60)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;
    int hit_cnt  = 0;
    int gl_cnt   = 0;
    int gr_cnt   = 0;
    int both_cnt = 0;

    // Pulse-width-sensitive counters: a pulse lasting two cycles counts twice.
    always @(negedge pclk) begin
        if (bus.hit === 1'b1)    hit_cnt++;
        if (bus.goal_l === 1'b1) gl_cnt++;
        if (bus.goal_r === 1'b1) gr_cnt++;
        if (bus.goal_l === 1'b1 && bus.goal_r === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, ".x"}, int'(bus.xpos), ex);
        check({tag, ".y"}, int'(bus.ypos), ey);
    endtask

    // One frame: vsync high for a cycle, then two low cycles so a GOAL settles.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk) bus.vsync_in = 1'b1;
            @(negedge pclk) bus.vsync_in = 1'b0;
            @(negedge pclk);
        end
    endtask

    task automatic pulse_start();
        @(negedge pclk) bus.start = 1'b1;
        @(negedge pclk) bus.start = 1'b0;
    endtask

    initial begin
        bus.vsync_in = 1'b0;
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.lpad_y   = 12'd300;
        bus.rpad_y   = 12'd420;
        repeat (3) @(negedge pclk);
        check_pos("reset", 392, 292);
        check("reset.playing", int'(bus.playing), 0);
        rst = 1'b1;

        ticks(10);
        check_pos("idle", 392, 292);
        check("idle.playing", int'(bus.playing), 0);
        check("idle.pulses", hit_cnt + gl_cnt + gr_cnt, 0);

        pulse_start();
        check("serve.playing", int'(bus.playing), 1);
        ticks(60);
        check_pos("serve60", 392, 292);
        check("serve60.playing", int'(bus.playing), 1);
        ticks(1);
        check_pos("play1", 396, 294);

        bus.start = 1'b1;
        ticks(84);
        check_pos("k85", 732, 462);
        ticks(1);
        check_pos("rhit", 736, 464);
        check("rhit.count", hit_cnt, 1);
        bus.rpad_y = 12'd0;
        ticks(1);
        check_pos("k87", 732, 466);

        bus.pause = 1'b1;
        ticks(5);
        check_pos("paused", 732, 466);
        bus.pause = 1'b0;
        ticks(1);
        check_pos("unpause", 728, 468);

        ticks(57);
        check_pos("k145", 500, 582);
        ticks(1);
        check_pos("bottom", 496, 584);
        ticks(1);
        check_pos("k147", 492, 582);

        ticks(110);
        check_pos("k257", 52, 362);
        ticks(1);
        check_pos("lhit", 48, 360);
        check("lhit.count", hit_cnt, 2);
        ticks(1);
        check_pos("k259", 52, 358);

        ticks(170);
        check_pos("k429", 732, 18);
        ticks(1);
        check_pos("rhit2", 736, 16);
        check("rhit2.count", hit_cnt, 3);
        bus.lpad_y = 12'd500;
        ticks(7);
        check_pos("k437", 708, 2);
        ticks(1);
        check_pos("top", 704, 0);
        ticks(1);
        check_pos("k439", 700, 2);

        ticks(174);
        check_pos("k613", 4, 350);
        check("miss.nohit", hit_cnt, 3);
        ticks(1);
        check_pos("goal_r", 392, 292);
        check("goal_r.count", gr_cnt, 1);
        check("goal_r.playing", int'(bus.playing), 1);
        ticks(60);
        check_pos("reserve", 392, 292);
        ticks(1);
        check_pos("serve_left", 388, 294);
        check("goal_l.none", gl_cnt, 0);

        ticks(10);
        check_pos("pre_rst", 348, 314);
        bus.start = 1'b0;
        @(negedge pclk);
        rst = 1'b0;
        #1;
        check_pos("async_rst", 392, 292);
        check("async_rst.playing", int'(bus.playing), 0);
        @(negedge pclk);
        rst = 1'b1;
        ticks(2);
        check("post_rst.idle", int'(bus.playing), 0);

        bus.rpad_y = 12'd0;
        pulse_start();
        ticks(60);
        ticks(85);
        check_pos("r_k85", 732, 462);
        ticks(12);
        check_pos("r_k97", 780, 486);
        check("r_miss.nohit", hit_cnt, 3);
        ticks(1);
        check_pos("goal_l", 392, 292);
        check("goal_l.count", gl_cnt, 1);
        check("goal_r.total", gr_cnt, 1);
        ticks(61);
        check_pos("serve_right", 396, 294);
        check("goals.exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
